// File: rtl/calc_pkg.sv
// Shared definitions for the I2C calculator command sequencer.
// Holds the sequencer state encoding, the status-byte bit positions, the
// operation encoding understood by the calculator datapath, and the read
// pointer values used when serving I2C read bytes.
package calc_pkg;

    // Sequencer states: opcode byte, operand A, operand B, wait for STOP, run.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GET_A = 3'd1,
        ST_GET_B = 3'd2,
        ST_ARMED = 3'd3,
        ST_RUN   = 3'd4
    } seq_state_e;

    // Bit positions inside the status byte.
    localparam int unsigned STAT_BUSY      = 7;
    localparam int unsigned STAT_DONE      = 6;
    localparam int unsigned STAT_CERR      = 5;
    localparam int unsigned STAT_FRAME_ERR = 4;
    localparam int unsigned STAT_OVERRUN   = 3;
    localparam int unsigned STAT_COLLISION = 2;
    localparam int unsigned STAT_TIMEOUT   = 1;

    // Operation codes shared with the calculator datapath.
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    // Read pointer values: which byte the next tx_req serves.
    localparam logic [1:0] PTR_STATUS = 2'd0;
    localparam logic [1:0] PTR_RES_HI = 2'd1;
    localparam logic [1:0] PTR_RES_LO = 2'd2;

    // An opcode byte is legal only when its upper five bits are zero.
    function automatic logic op_byte_ok(input logic [7:0] b);
        return (b[7:3] == 5'd0);
    endfunction

endpackage

// File: rtl/calc_seq_watchdog.sv
// Watchdog counter for the calculator sequencer.
// Counts enabled cycles since the last clear and flags expiry on the
// LIMIT-th enabled cycle (the cycle whose count equals LIMIT-1).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart the count from zero
//   en        : count this cycle
//   expired   : high while enabled and LIMIT cycles have elapsed
module calc_seq_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LAST_C = 16'(LIMIT - 1);

    logic [15:0] cnt_r;

    assign expired = en && (cnt_r == LAST_C);

    // Cycle counter; saturates at the expiry value until cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (clr) begin
            cnt_r <= 16'd0;
        end else if (en && !expired) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Command sequencer between the I2C target byte interface and the
// calculator datapath. Assembles an opcode/A/B write frame, launches the
// calculator on STOP, latches the 16-bit result and serves status and
// result bytes on I2C reads.
// Optional feature: define CALC_SEQ_TIMEOUT_EN to add a watchdog that
// aborts an operation after TIMEOUT_CYCLES cycles without calc_done.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   rx_valid, rx_data        : received write byte strobe and data
//   i2c_stop                 : STOP / repeated START pulse
//   rd_start, tx_req         : read addressed pulse, next read byte request
//   tx_data                  : registered read byte
//   calc_op, calc_a, calc_b  : operation and operands to the calculator
//   calc_start               : one-cycle launch pulse
//   calc_done, calc_result,
//   calc_err                 : completion pulse, result and error flag
//   busy                     : operation in flight
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        i2c_stop,
    input  logic        rd_start,
    input  logic        tx_req,
    output logic [7:0]  tx_data,
    output logic [2:0]  calc_op,
    output logic [7:0]  calc_a,
    output logic [7:0]  calc_b,
    output logic        calc_start,
    input  logic        calc_done,
    input  logic [15:0] calc_result,
    input  logic        calc_err,
    output logic        busy
);

    seq_state_e  state_r;
    logic        drop_r;
    logic        done_r;
    logic        cerr_r;
    logic        ferr_r;
    logic        ovr_r;
    logic        col_r;
    logic        to_r;
    logic [15:0] res_r;
    logic [1:0]  ptr_r;

    logic [7:0]  status_s;
    logic [1:0]  ptr_eff_s;
    logic        wd_expired_s;

`ifdef CALC_SEQ_TIMEOUT_EN
    calc_seq_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_r != ST_RUN),
        .en      (state_r == ST_RUN),
        .expired (wd_expired_s)
    );
`else
    // No watchdog: RUN only ends on calc_done.
    assign wd_expired_s = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    // Status byte and effective read pointer (rd_start takes precedence).
    always_comb begin
        status_s = {busy, done_r, cerr_r, ferr_r, ovr_r, col_r, to_r, 1'b0};
        if (rd_start) begin
            ptr_eff_s = PTR_STATUS;
        end else begin
            ptr_eff_s = ptr_r;
        end
    end

    // Read port, frame FSM and flags. Flag clears from reads come first so
    // that a set from the FSM in the same cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            drop_r     <= 1'b0;
            done_r     <= 1'b0;
            cerr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            ovr_r      <= 1'b0;
            col_r      <= 1'b0;
            to_r       <= 1'b0;
            res_r      <= 16'd0;
            ptr_r      <= PTR_STATUS;
            tx_data    <= 8'd0;
            calc_op    <= 3'd0;
            calc_a     <= 8'd0;
            calc_b     <= 8'd0;
            calc_start <= 1'b0;
            busy       <= 1'b0;
        end else begin
            calc_start <= 1'b0;

            if (tx_req) begin
                case (ptr_eff_s)
                    PTR_STATUS: begin
                        tx_data <= status_s;
                        ferr_r  <= 1'b0;
                        ovr_r   <= 1'b0;
                        col_r   <= 1'b0;
                        to_r    <= 1'b0;
                        ptr_r   <= PTR_RES_HI;
                    end
                    PTR_RES_HI: begin
                        tx_data <= res_r[15:8];
                        ptr_r   <= PTR_RES_LO;
                    end
                    PTR_RES_LO: begin
                        tx_data <= res_r[7:0];
                        done_r  <= 1'b0;
                        ptr_r   <= PTR_STATUS;
                    end
                    default: begin
                        tx_data <= status_s;
                        ptr_r   <= PTR_STATUS;
                    end
                endcase
            end else begin
                ptr_r <= ptr_eff_s;
            end

            // A STOP ends any dropping of a bad frame's trailing bytes.
            if (i2c_stop) begin
                drop_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (rx_valid && !drop_r) begin
                        if (op_byte_ok(rx_data)) begin
                            calc_op <= rx_data[2:0];
                            if (i2c_stop) begin
                                ferr_r  <= 1'b1;
                                state_r <= ST_IDLE;
                            end else begin
                                state_r <= ST_GET_A;
                            end
                        end else begin
                            ferr_r  <= 1'b1;
                            state_r <= ST_IDLE;
                            if (!i2c_stop) begin
                                drop_r <= 1'b1;
                            end
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GET_A: begin
                    if (rx_valid) begin
                        calc_a <= rx_data;
                    end
                    if (i2c_stop) begin
                        ferr_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else if (rx_valid) begin
                        state_r <= ST_GET_B;
                    end else begin
                        state_r <= ST_GET_A;
                    end
                end
                ST_GET_B: begin
                    if (rx_valid) begin
                        calc_b <= rx_data;
                    end
                    if (i2c_stop && rx_valid) begin
                        // B byte and STOP together complete a valid frame.
                        calc_start <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= ST_RUN;
                    end else if (i2c_stop) begin
                        ferr_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else if (rx_valid) begin
                        state_r <= ST_ARMED;
                    end else begin
                        state_r <= ST_GET_B;
                    end
                end
                ST_ARMED: begin
                    if (rx_valid) begin
                        ovr_r <= 1'b1;
                    end
                    if (i2c_stop) begin
                        calc_start <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= ST_RUN;
                    end else begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_RUN: begin
                    if (rx_valid) begin
                        col_r <= 1'b1;
                    end
                    if (calc_done) begin
                        res_r   <= calc_result;
                        cerr_r  <= calc_err;
                        done_r  <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (wd_expired_s) begin
                        to_r    <= 1'b1;
                        res_r   <= 16'hFFFF;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: directed scenarios plus random
// frames, a transaction-level reference model, and a scoreboard monitor
// that checks launches and read bytes as the DUT presents them.
module tb_calc_seq_ctrl;

`ifdef CALC_SEQ_TIMEOUT_EN
    localparam int unsigned TIMEOUT_C = 16;
`else
    localparam int unsigned TIMEOUT_C = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        i2c_stop = 1'b0;
    logic        rd_start = 1'b0;
    logic        tx_req = 1'b0;
    logic [7:0]  tx_data;
    logic [2:0]  calc_op;
    logic [7:0]  calc_a;
    logic [7:0]  calc_b;
    logic        calc_start;
    logic        calc_done = 1'b0;
    logic [15:0] calc_result = 16'd0;
    logic        calc_err = 1'b0;
    logic        busy;

    calc_seq_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_C)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .i2c_stop(i2c_stop), .rd_start(rd_start), .tx_req(tx_req),
        .tx_data(tx_data), .calc_op(calc_op), .calc_a(calc_a), .calc_b(calc_b),
        .calc_start(calc_start), .calc_done(calc_done),
        .calc_result(calc_result), .calc_err(calc_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic txq_d = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        txq_d <= tx_req;
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         at;
    } launch_t;

    launch_t    exp_launch[$];
    logic [7:0] exp_tx[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: compares whatever the DUT presents against the queues.
    always @(negedge clk) begin
        launch_t    l;
        logic [7:0] e;
        if (!rst) begin
            if (txq_d) begin
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_data", {24'd0, tx_data}, {24'd0, e});
                end
            end
            if (calc_start) begin
                if (exp_launch.size() == 0) begin
                    check("launch_unexpected", 32'd1, 32'd0);
                end else begin
                    l = exp_launch.pop_front();
                    check("launch_op", {29'd0, calc_op}, {29'd0, l.op});
                    check("launch_a", {24'd0, calc_a}, {24'd0, l.a});
                    check("launch_b", {24'd0, calc_b}, {24'd0, l.b});
                    check("launch_cycle", cyc, l.at);
                end
            end
        end
    end

    // Reference model: frame as a byte list, flags as plain bits.
    bit         m_busy, m_done, m_cerr, m_ferr, m_ovr, m_col, m_to, m_bad;
    logic [15:0] m_res;
    int         m_ptr;
    logic [7:0] m_frame[$];
    logic [2:0] m_op;
    logic [7:0] m_a, m_b;

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_cerr = 0; m_ferr = 0; m_ovr = 0;
        m_col = 0; m_to = 0; m_bad = 0; m_res = 16'd0; m_ptr = 0;
        m_frame.delete();
    endtask

    // One clock of stimulus; the model applies reads, then byte, stop, completion.
    task automatic step(input bit rxv, input logic [7:0] d, input bit stop,
                        input bit rds, input bit txr, input bit dn,
                        input logic [15:0] r, input bit e);
        launch_t l;
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        rx_valid = rxv; rx_data = d; i2c_stop = stop; rd_start = rds;
        tx_req = txr; calc_done = dn; calc_result = r; calc_err = e;
        if (rds) m_ptr = 0;
        if (txr) begin
            if (m_ptr == 0) begin
                exp_tx.push_back({m_busy, m_done, m_cerr, m_ferr, m_ovr, m_col, m_to, 1'b0});
                m_ferr = 0; m_ovr = 0; m_col = 0; m_to = 0;
            end else if (m_ptr == 1) begin
                exp_tx.push_back(m_res[15:8]);
            end else begin
                exp_tx.push_back(m_res[7:0]);
                m_done = 0;
            end
            m_ptr = (m_ptr + 1) % 3;
        end
        if (rxv) begin
            if (m_busy) m_col = 1;
            else if (m_bad) m_bad = 1;
            else if (m_frame.size() == 0) begin
                if (d > 8'd7) begin m_ferr = 1; m_bad = 1; end
                else m_frame.push_back(d);
            end else if (m_frame.size() < 3) m_frame.push_back(d);
            else m_ovr = 1;
        end
        if (stop && !m_busy) begin
            if (m_frame.size() == 3) begin
                m_op = m_frame[0][2:0]; m_a = m_frame[1]; m_b = m_frame[2];
                l.op = m_op; l.a = m_a; l.b = m_b; l.at = cyc + 1;
                exp_launch.push_back(l);
                m_busy = 1;
            end else if (m_frame.size() != 0) begin
                m_ferr = 1;
            end
            m_frame.delete();
            m_bad = 0;
        end
        if (dn && m_busy) begin
            check("hold_op", {29'd0, calc_op}, {29'd0, m_op});
            check("hold_a", {24'd0, calc_a}, {24'd0, m_a});
            check("hold_b", {24'd0, calc_b}, {24'd0, m_b});
            m_res = r; m_cerr = e; m_done = 1; m_busy = 0;
        end
        @(posedge clk); #1;
        rx_valid = 0; i2c_stop = 0; rd_start = 0; tx_req = 0; calc_done = 0;
    endtask

    task automatic idle();                 step(0, 8'd0, 0, 0, 0, 0, 16'd0, 0); endtask
    task automatic wr(input logic [7:0] b); step(1, b, 0, 0, 0, 0, 16'd0, 0);   endtask
    task automatic wrs(input logic [7:0] b); step(1, b, 1, 0, 0, 0, 16'd0, 0);  endtask
    task automatic stp();                  step(0, 8'd0, 1, 0, 0, 0, 16'd0, 0); endtask
    task automatic rd();                   step(0, 8'd0, 0, 1, 0, 0, 16'd0, 0); endtask
    task automatic tx();                   step(0, 8'd0, 0, 0, 1, 0, 16'd0, 0); endtask
    task automatic fin(input logic [15:0] r, input bit e); step(0, 8'd0, 0, 0, 0, 1, r, e); endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check({tag, "_calc_op"}, {29'd0, calc_op}, 32'd0);
        check({tag, "_calc_a"}, {24'd0, calc_a}, 32'd0);
        check({tag, "_calc_b"}, {24'd0, calc_b}, 32'd0);
        check({tag, "_calc_start"}, {31'd0, calc_start}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 0;

        // Basic multiply, done 4 cycles after STOP, then a full read plus wrap.
        wr(8'h02); wr(8'h0C); wr(8'h05); stp();
        repeat (3) idle();
        fin(16'h003C, 0);
        rd(); tx(); tx(); tx(); tx();

        // Short frame: frame error, no launch.
        wr(8'h01); wr(8'h07); stp(); idle();
        rd(); tx();

        // Overrun frame, status read while busy.
        wr(8'h01); wr(8'h01); wr(8'h02); wr(8'h03); stp(); idle();
        rd(); tx();
        fin(16'h0003, 0);
        rd(); tx(); tx(); tx();

        // Collision during RUN; result still latched; calc_err reported.
        wr(8'h03); wr(8'h40); wr(8'h00); stp(); idle(); wr(8'h01); idle();
        fin(16'hBEEF, 1);
        rd(); tx(); tx(); tx();

        // B byte with STOP together; completion on the low-byte read cycle.
        wr(8'h00); wr(8'h03); wrs(8'h04); idle();
        rd(); tx(); tx();
        step(0, 8'd0, 0, 0, 1, 1, 16'h0007, 0);
        step(0, 8'd0, 0, 1, 1, 0, 16'd0, 0);
        tx(); tx();

        // Bad opcode: trailing bytes dropped until STOP; stray calc_done ignored.
        wr(8'hFF); wr(8'h00); wr(8'h01); wr(8'h02); stp();
        fin(16'h5555, 0);
        rd(); tx(); tx(); tx();

        // Reset mid-RUN, then a late calc_done.
        wr(8'h03); wr(8'h09); wrs(8'h04); idle(); idle();
        rst = 1; @(posedge clk); #1; rst = 0;
        model_reset();
        fin(16'h1234, 0);
        check_all_zero("midrun_reset");
        rd(); tx(); tx(); tx();

`ifdef CALC_SEQ_TIMEOUT_EN
        // Watchdog expiry 16 cycles after calc_start.
        wr(8'h02); wr(8'h03); wr(8'h04); stp();
        repeat (15) idle();
        check("timeout_busy_hold", {31'd0, busy}, 32'd1);
        rx_valid = 0;
        @(posedge clk); #1;
        check("timeout_busy_drop", {31'd0, busy}, 32'd0);
        m_busy = 0; m_to = 1; m_res = 16'hFFFF;
        rd(); tx(); tx(); tx();
`endif

        // Random frames with interleaved reads, collisions and completions.
        for (int it = 0; it < 80; it++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                logic [7:0] b;
                bit last_stop;
                b = 8'($urandom);
                if (k == 0 && ($urandom % 4) != 0) b = 8'($urandom_range(0, 7));
                last_stop = (k == n - 1) && ($urandom % 2 == 1);
                step(1, b, last_stop, 0, ($urandom % 5) == 0, 0, 16'd0, 0);
                if (k == n - 1 && !last_stop) stp();
            end
            if (m_busy) begin
                int dly;
                dly = $urandom_range(0, 8);
                for (int k = 0; k < dly; k++) begin
                    step(($urandom % 5) == 0, 8'($urandom), 0,
                         ($urandom % 6) == 0, ($urandom % 3) == 0, 0, 16'd0, 0);
                end
                step(($urandom % 6) == 0, 8'($urandom), 0, 0, ($urandom % 4) == 0,
                     1, 16'($urandom), 1'($urandom));
            end
            for (int k = 0; k < $urandom_range(0, 4); k++) begin
                step(0, 8'd0, 0, ($urandom % 3) == 0, 1, 0, 16'd0, 0);
            end
        end

        idle(); idle();
        check("pending_tx", exp_tx.size(), 32'd0);
        check("pending_launch", exp_launch.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
